// File: rtl/mips_ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, branch/jump redirect and syscall handling.
// Optional syscall support is enabled with the CPU_EX_SYSCALL_EN macro.
module mips_ex_stage #(
  parameter int CON_W = 17
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      current_pc,
  input  logic [31:0]      ins,
  input  logic [CON_W-1:0] controls,
  input  logic [31:0]      reg_read1_data,
  input  logic [31:0]      reg_read2_data,
  input  logic [31:0]      _syscall_reg_v0,
  input  logic [31:0]      _syscall_reg_a0,
  output logic [31:0]      current_pc_ex,
  output logic [31:0]      ins_ex,
  output logic [CON_W-1:0] controls_ex,
  output logic [31:0]      reg_read2_data_ex,
  output logic [31:0]      alu_result,
  output logic             alu_zero,
  output logic [31:0]      next_pc_realtime,
  output logic [1:0]       pc_inc_realtime,
  output logic             reg_write_en,
  output logic [4:0]       reg_write_num,
  output logic [4:0]       reg_write_num_realtime,
  output logic [31:0]      _syscall_display,
  output logic             _debug_syscall,
  output logic [1:0]       _debug_syscall_pc_inc_mask
);

  logic [31:0]      pc_q, ins_q, rs_q, rt_q;
  logic [CON_W-1:0] ctl_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q  <= '0;
      ins_q <= '0;
      ctl_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
    end else begin
      pc_q  <= current_pc;
      ins_q <= ins;
      ctl_q <= controls;
      rs_q  <= reg_read1_data;
      rt_q  <= reg_read2_data;
    end
  end

  assign current_pc_ex     = pc_q;
  assign ins_ex            = ins_q;
  assign controls_ex       = ctl_q;
  assign reg_read2_data_ex = rt_q;

  logic [3:0]  alu_op;
  logic [31:0] imm, op_a, op_b, alu_raw, pc_plus4, br_target, j_target;
  logic        taken, redirect;

  assign alu_op = ctl_q[3:0];
  assign imm    = ctl_q[5] ? {16'b0, ins_q[15:0]} : {{16{ins_q[15]}}, ins_q[15:0]};
  assign op_a   = ctl_q[16] ? {27'b0, ins_q[10:6]} : rs_q;
  assign op_b   = ctl_q[4] ? imm : rt_q;

  always_comb begin
    alu_raw = '0;
    case (alu_op)
      4'd0:  alu_raw = op_a + op_b;
      4'd1:  alu_raw = op_a - op_b;
      4'd2:  alu_raw = op_a & op_b;
      4'd3:  alu_raw = op_a | op_b;
      4'd4:  alu_raw = op_a ^ op_b;
      4'd5:  alu_raw = ~(op_a | op_b);
      4'd6:  alu_raw = {31'b0, $signed(op_a) < $signed(op_b)};
      4'd7:  alu_raw = {31'b0, op_a < op_b};
      4'd8:  alu_raw = op_b << op_a[4:0];
      4'd9:  alu_raw = op_b >> op_a[4:0];
      4'd10: alu_raw = $unsigned($signed(op_b) >>> op_a[4:0]);
      4'd11: alu_raw = {op_b[15:0], 16'b0};
      default: alu_raw = '0;
    endcase
  end

  assign pc_plus4   = pc_q + 32'd4;
  assign alu_result = ctl_q[8] ? pc_plus4 : alu_raw;
  assign alu_zero   = (alu_result == 32'd0);

  assign reg_write_num          = ctl_q[8] ? 5'd31 : (ctl_q[6] ? ins_q[15:11] : ins_q[20:16]);
  assign reg_write_en           = ctl_q[7] && (reg_write_num != 5'd0);
  assign reg_write_num_realtime = reg_write_en ? reg_write_num : 5'd0;

  assign br_target = pc_plus4 + {{14{ins_q[15]}}, ins_q[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ins_q[25:0], 2'b00};
  assign taken     = (ctl_q[11] && (rs_q == rt_q)) || (ctl_q[12] && (rs_q != rt_q));
  assign redirect  = ctl_q[14] || ctl_q[13] || taken;

  always_comb begin
    next_pc_realtime = pc_plus4;
    if (ctl_q[14])      next_pc_realtime = rs_q;
    else if (ctl_q[13]) next_pc_realtime = j_target;
    else if (taken)     next_pc_realtime = br_target;
  end

  assign pc_inc_realtime = {1'b0, redirect} | _debug_syscall_pc_inc_mask;

`ifdef CPU_EX_SYSCALL_EN
  logic        halted_q, halted_d;
  logic [31:0] display_q, display_d;
  logic        sys_exit;

  assign _debug_syscall = ctl_q[15];
  assign sys_exit       = ctl_q[15] && (_syscall_reg_v0 == 32'd10);

  always_comb begin
    halted_d  = halted_q | sys_exit;
    display_d = display_q;
    if (ctl_q[15] && (_syscall_reg_v0 == 32'd34)) display_d = _syscall_reg_a0;
  end

  // Halt is sticky: once exit is seen, PC holds until reset regardless of EX contents.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      halted_q  <= 1'b0;
      display_q <= '0;
    end else begin
      halted_q  <= halted_d;
      display_q <= display_d;
    end
  end

  assign _debug_syscall_pc_inc_mask = (halted_q || sys_exit) ? 2'b11 : 2'b00;
  assign _syscall_display           = display_q;
`else
  logic unused_syscall;
  assign unused_syscall             = ^{_syscall_reg_v0, _syscall_reg_a0, ctl_q[15]};
  assign _debug_syscall             = 1'b0;
  assign _debug_syscall_pc_inc_mask = 2'b00;
  assign _syscall_display           = '0;
`endif

endmodule

// File: tb/tb_mips_ex_stage.sv
// Scoreboard bench for mips_ex_stage: directed vectors push expectations, a monitor checks them.
module tb_mips_ex_stage;
  localparam int CON_W = 17;
`ifdef CPU_EX_SYSCALL_EN
  localparam bit SYS_ON = 1'b1;
`else
  localparam bit SYS_ON = 1'b0;
`endif

  localparam logic [16:0] IMM = 17'h00010, ZX = 17'h00020, RD = 17'h00040, RW = 17'h00080;
  localparam logic [16:0] LNK = 17'h00100, BEQ = 17'h00800, BNE = 17'h01000, JMP = 17'h02000;
  localparam logic [16:0] JR = 17'h04000, SYS = 17'h08000, SH = 17'h10000;

  logic clk = 1'b0, clr = 1'b0;
  logic [31:0] current_pc = '0, ins = '0, rd1 = '0, rd2 = '0, v0 = '0, a0 = '0;
  logic [CON_W-1:0] controls = '0;
  logic [31:0] current_pc_ex, ins_ex, reg_read2_data_ex, alu_result, next_pc_realtime, disp;
  logic [CON_W-1:0] controls_ex;
  logic alu_zero, reg_write_en, dbg_sys;
  logic [1:0] pc_inc, mask;
  logic [4:0] reg_write_num, rwn_rt;

  mips_ex_stage #(.CON_W(CON_W)) dut (
    .clk(clk), .clr(clr), .current_pc(current_pc), .ins(ins), .controls(controls),
    .reg_read1_data(rd1), .reg_read2_data(rd2), ._syscall_reg_v0(v0), ._syscall_reg_a0(a0),
    .current_pc_ex(current_pc_ex), .ins_ex(ins_ex), .controls_ex(controls_ex),
    .reg_read2_data_ex(reg_read2_data_ex), .alu_result(alu_result), .alu_zero(alu_zero),
    .next_pc_realtime(next_pc_realtime), .pc_inc_realtime(pc_inc), .reg_write_en(reg_write_en),
    .reg_write_num(reg_write_num), .reg_write_num_realtime(rwn_rt), ._syscall_display(disp),
    ._debug_syscall(dbg_sys), ._debug_syscall_pc_inc_mask(mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins, alu, npc, disp;
    logic [1:0]  pci;
    logic [4:0]  rwn, rt;
    logic        en, dbg;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue(input string name, input logic clr_v, input logic [31:0] pc,
                       input logic [31:0] i, input logic [16:0] c, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] v, input logic [31:0] a,
                       input logic [31:0] e_alu, input logic [31:0] e_npc, input logic [1:0] e_pci,
                       input logic [4:0] e_rwn, input logic e_en, input logic [31:0] e_disp,
                       input logic e_dbg);
    exp_t e;
    @(negedge clk); #1;
    clr = clr_v; current_pc = pc; ins = i; controls = c; rd1 = rs; rd2 = rt; v0 = v; a0 = a;
    e.name = name; e.ins = clr_v ? i : 32'd0; e.alu = e_alu; e.npc = e_npc; e.pci = e_pci;
    e.rwn = e_rwn; e.en = e_en; e.rt = e_en ? e_rwn : 5'd0; e.disp = e_disp; e.dbg = e_dbg;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".ins_ex"}, ins_ex, e.ins);
        chk({e.name, ".alu"}, alu_result, e.alu);
        chk({e.name, ".zero"}, {31'b0, alu_zero}, {31'b0, e.alu == 32'd0});
        chk({e.name, ".npc"}, next_pc_realtime, e.npc);
        chk({e.name, ".pc_inc"}, {30'b0, pc_inc}, {30'b0, e.pci});
        chk({e.name, ".rwn"}, {27'b0, reg_write_num}, {27'b0, e.rwn});
        chk({e.name, ".we"}, {31'b0, reg_write_en}, {31'b0, e.en});
        chk({e.name, ".rwn_rt"}, {27'b0, rwn_rt}, {27'b0, e.rt});
        chk({e.name, ".disp"}, disp, e.disp);
        chk({e.name, ".dbg"}, {31'b0, dbg_sys}, {31'b0, e.dbg});
      end
    end
  end

  initial begin : stim
    logic [31:0] db;
    db = SYS_ON ? 32'hDEADBEEF : 32'd0;
    issue("reset", 0, 32'h0, 32'h0, 17'h0, 0, 0, 0, 0, 32'h0, 32'h4, 2'b00, 5'd0, 0, 0, 0);
    issue("addi", 1, 32'h1000, {6'h08, 5'd1, 5'd8, 16'hFFFF}, IMM | RW, 5, 0, 0, 0,
          32'd4, 32'h1004, 2'b00, 5'd8, 1, 0, 0);
    issue("addi_r0", 1, 32'h1000, {6'h08, 5'd1, 5'd0, 16'hFFFF}, IMM | RW, 5, 0, 0, 0,
          32'd4, 32'h1004, 2'b00, 5'd0, 0, 0, 0);
    issue("beq_t", 1, 32'h100, {6'h04, 5'd2, 5'd3, 16'h0003}, BEQ | 17'd1, 7, 7, 0, 0,
          32'd0, 32'h110, 2'b01, 5'd3, 0, 0, 0);
    issue("beq_nt", 1, 32'h100, {6'h04, 5'd2, 5'd3, 16'h0003}, BEQ | 17'd1, 7, 8, 0, 0,
          32'hFFFFFFFF, 32'h104, 2'b00, 5'd3, 0, 0, 0);
    issue("bne_back", 1, 32'h200, {6'h05, 5'd2, 5'd3, 16'hFFFE}, BNE | 17'd1, 7, 8, 0, 0,
          32'hFFFFFFFF, 32'h1FC, 2'b01, 5'd3, 0, 0, 0);
    issue("jal", 1, 32'h00400010, {6'h03, 26'h40}, JMP | LNK | RW, 0, 0, 0, 0,
          32'h00400014, 32'h100, 2'b01, 5'd31, 1, 0, 0);
    issue("jr_prio", 1, 32'h300, 32'h03E00008, JR | JMP | BEQ, 32'h12345678, 32'h12345678, 0, 0,
          32'h2468ACF0, 32'h12345678, 2'b01, 5'd0, 0, 0, 0);
    issue("sra", 1, 32'h1000, {6'h0, 5'd0, 5'd9, 5'd10, 5'd4, 6'h03}, 17'd10 | SH | RD | RW,
          7, 32'h80000000, 0, 0, 32'hF8000000, 32'h1004, 2'b00, 5'd10, 1, 0, 0);
    issue("sltu", 1, 32'h1000, {6'h0, 5'd1, 5'd2, 5'd11, 5'd0, 6'h2B}, 17'd7 | RD | RW,
          1, 32'hFFFFFFFF, 0, 0, 32'd1, 32'h1004, 2'b00, 5'd11, 1, 0, 0);
    issue("slt", 1, 32'h1000, {6'h0, 5'd1, 5'd2, 5'd11, 5'd0, 6'h2A}, 17'd6 | RD | RW,
          1, 32'hFFFFFFFF, 0, 0, 32'd0, 32'h1004, 2'b00, 5'd11, 1, 0, 0);
    issue("lui", 1, 32'h1000, {6'h0F, 5'd0, 5'd12, 16'hABCD}, 17'd11 | IMM | ZX | RW, 0, 0, 0, 0,
          32'hABCD0000, 32'h1004, 2'b00, 5'd12, 1, 0, 0);
    issue("ori_zx", 1, 32'h1000, {6'h0D, 5'd4, 5'd13, 16'h8001}, 17'd3 | IMM | ZX | RW,
          32'h0000F000, 0, 0, 0, 32'h0000F001, 32'h1004, 2'b00, 5'd13, 1, 0, 0);
    issue("sll31", 1, 32'h1000, {6'h0, 5'd0, 5'd9, 5'd14, 5'd31, 6'h00}, 17'd8 | SH | RD | RW,
          0, 3, 0, 0, 32'h80000000, 32'h1004, 2'b00, 5'd14, 1, 0, 0);
    issue("sys_disp", 1, 32'h2000, 32'h0000000C, SYS, 0, 0, 34, 32'hDEADBEEF,
          32'd0, 32'h2004, 2'b00, 5'd0, 0, 0, SYS_ON);
    issue("disp_upd", 1, 32'h2004, 32'h0, 17'h0, 0, 0, 34, 32'hDEADBEEF,
          32'd0, 32'h2008, 2'b00, 5'd0, 0, db, 0);
    issue("sys_exit", 1, 32'h2008, 32'h0000000C, SYS, 0, 0, 10, 0,
          32'd0, 32'h200C, SYS_ON ? 2'b11 : 2'b00, 5'd0, 0, db, SYS_ON);
    issue("halt_nop", 1, 32'h200C, 32'h0, 17'h0, 0, 0, 10, 0,
          32'd0, 32'h2010, SYS_ON ? 2'b11 : 2'b00, 5'd0, 0, db, 0);
    issue("halt_beq", 1, 32'h100, {6'h04, 5'd2, 5'd3, 16'h0003}, BEQ | 17'd1, 7, 7, 0, 0,
          32'd0, 32'h110, SYS_ON ? 2'b11 : 2'b01, 5'd3, 0, db, 0);
    issue("halt_hold", 1, 32'h2010, 32'h0, 17'h0, 0, 0, 0, 0,
          32'd0, 32'h2014, SYS_ON ? 2'b11 : 2'b00, 5'd0, 0, db, 0);
    issue("rst_mid", 0, 32'h5000, 32'h0000000C, SYS, 0, 0, 10, 0,
          32'd0, 32'h4, 2'b00, 5'd0, 0, 0, 0);
    issue("post_rst", 1, 32'h40, 32'h0, 17'h0, 0, 0, 0, 0,
          32'd0, 32'h44, 2'b00, 5'd0, 0, 0, 0);
    begin : drain
      int budget;
      budget = 10;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb.size() > 0) begin
        n_checks++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
